prog_sequencer: RTL and testbench

Run controller that sequences the processor core through one program per request. It sits between the bench-side request interface and the core's `req`/`ack` pins. On each request it:
- selects a program start address,
- pulses the core start,
- counts executed cycles until the core halts,
- reports done, cycle count, and a watchdog fault.

---
 rtl/prog_sequencer_pkg.sv | 27 ++
 rtl/prog_sequencer_run_counter.sv | 22 ++
 rtl/prog_sequencer.sv | 84 ++++++++
 tb/tb_prog_sequencer.sv | 136 +++++++++++++
 4 files changed

// File: rtl/prog_sequencer_pkg.sv
// Shared types and constants for the program run sequencer.
package definitions;

  localparam int kSEQ_CNT_W = 16;
  localparam int kNUM_BASE  = 3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_RUN    = 3'd2,
    S_DONE   = 3'd3,
    S_FAULT  = 3'd4
  } seq_state_t;

  localparam logic [9:0] kPROG_BASE [kNUM_BASE] = '{10'd0, 10'd128, 10'd256};

  // Indices without a table entry map to address 0 instead of reading past the table.
  function automatic logic [9:0] prog_base(input logic [1:0] idx);
    logic [9:0] addr;
    addr = '0;
    for (int i = 0; i < kNUM_BASE; i++) begin
      if (idx == 2'(i)) addr = kPROG_BASE[i];
    end
    return addr;
  endfunction

endpackage

// File: rtl/prog_sequencer_run_counter.sv
// Clearable up-counter with enable; at_limit flags the last count before LIMIT.
module run_counter
  import definitions::*;
#(
  parameter int W     = kSEQ_CNT_W,
  parameter int LIMIT = 20000
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         at_limit
);

  always_ff @(posedge clk) begin
    if (clr)     count <= '0;
    else if (en) count <= count + W'(1);
  end

  assign at_limit = (count == W'(LIMIT - 1));

endmodule

// File: rtl/prog_sequencer.sv
// Sequences the core through one program per accepted request and reports
// completion, the number of RUN cycles spent, and a watchdog/invalid-index fault.
module prog_sequencer
  import definitions::*;
#(
  parameter int NUM_PROGS  = 3,
  parameter int MAX_CYCLES = 20000
) (
  input  logic                  clk,
  input  logic                  init,
  input  logic                  start_req,
  input  logic [1:0]            prog_sel,
  input  logic                  core_halt,
  output logic                  core_start,
  output logic [9:0]            start_addr,
  output logic [1:0]            run_prog,
  output logic                  busy,
  output logic                  done,
  output logic                  fault,
  output logic [kSEQ_CNT_W-1:0] cycle_count
);

  seq_state_t state, state_nxt;
  logic       accept;
  logic       sel_valid;
  logic       at_limit;
  logic       cnt_en;

  assign sel_valid = (int'(prog_sel) < NUM_PROGS);
  assign accept    = start_req &&
                     (state == S_IDLE || state == S_DONE || state == S_FAULT);
  assign cnt_en    = (state == S_RUN) && !core_halt;

  always_ff @(posedge clk) begin
    if (init) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_FAULT: begin
        if (start_req) state_nxt = sel_valid ? S_LAUNCH : S_FAULT;
      end
      S_LAUNCH: state_nxt = S_RUN;
      S_RUN: begin
        // A halt in the same cycle the watchdog expires still counts as a clean finish.
        if (core_halt)     state_nxt = S_DONE;
        else if (at_limit) state_nxt = S_FAULT;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    core_start = (state == S_LAUNCH);
    busy       = (state == S_LAUNCH) || (state == S_RUN);
    done       = (state == S_DONE) || (state == S_FAULT);
    fault      = (state == S_FAULT);
  end

  always_ff @(posedge clk) begin
    if (init) begin
      run_prog   <= '0;
      start_addr <= '0;
    end else if (accept) begin
      run_prog   <= prog_sel;
      start_addr <= sel_valid ? prog_base(prog_sel) : 10'd0;
    end
  end

  // The watchdog step from MAX_CYCLES-1 to MAX_CYCLES is an ordinary increment.
  run_counter #(
    .W     (kSEQ_CNT_W),
    .LIMIT (MAX_CYCLES)
  ) u_run_counter (
    .clk      (clk),
    .clr      (init || accept),
    .en       (cnt_en),
    .count    (cycle_count),
    .at_limit (at_limit)
  );

endmodule

// File: tb/tb_prog_sequencer.sv
// Drives two sequencers (default watchdog and a 10-cycle watchdog) from shared inputs.
module tb_prog_sequencer;

  localparam int MAX_A = 20000;
  localparam int MAX_W = 10;

  logic       clk = 1'b0;
  logic       init, start_req, core_halt;
  logic [1:0] prog_sel;

  logic        a_core_start, a_busy, a_done, a_fault;
  logic [9:0]  a_start_addr;
  logic [1:0]  a_run_prog;
  logic [15:0] a_cycle_count;
  logic        w_core_start, w_busy, w_done, w_fault;
  logic [9:0]  w_start_addr;
  logic [1:0]  w_run_prog;
  logic [15:0] w_cycle_count;
  logic [31:0] a_obs, w_obs;

  int passed = 0;
  int total  = 0;
  int base_tab [3] = '{0, 128, 256};

  always #5 clk = ~clk;

  prog_sequencer #(.NUM_PROGS(3), .MAX_CYCLES(MAX_A)) dut_a (
    .clk(clk), .init(init), .start_req(start_req), .prog_sel(prog_sel),
    .core_halt(core_halt), .core_start(a_core_start), .start_addr(a_start_addr),
    .run_prog(a_run_prog), .busy(a_busy), .done(a_done), .fault(a_fault),
    .cycle_count(a_cycle_count)
  );

  prog_sequencer #(.NUM_PROGS(3), .MAX_CYCLES(MAX_W)) dut_w (
    .clk(clk), .init(init), .start_req(start_req), .prog_sel(prog_sel),
    .core_halt(core_halt), .core_start(w_core_start), .start_addr(w_start_addr),
    .run_prog(w_run_prog), .busy(w_busy), .done(w_done), .fault(w_fault),
    .cycle_count(w_cycle_count)
  );

  assign a_obs = {a_core_start, a_busy, a_done, a_fault, a_run_prog, a_start_addr, a_cycle_count};
  assign w_obs = {w_core_start, w_busy, w_done, w_fault, w_run_prog, w_start_addr, w_cycle_count};

  function automatic logic [31:0] pack(input logic cs, input logic b, input logic d,
                                       input logic f, input int rp, input int sa, input int cc);
    return {cs, b, d, f, 2'(rp), 10'(sa), 16'(cc)};
  endfunction

  // Expected outputs e edges after a request for program sel whose core halts after h
  // non-halt RUN cycles, under watchdog limit m.
  function automatic logic [31:0] expect_at(input int e, input int sel, input int h, input int m);
    int addr;
    if (sel >= 3) return pack(0, 0, 1, 1, sel, 0, 0);
    addr = base_tab[sel];
    if (e == 1) return pack(1, 1, 0, 0, sel, addr, 0);
    if (h < m) begin
      if (e <= 2 + h) return pack(0, 1, 0, 0, sel, addr, e - 2);
      return pack(0, 0, 1, 0, sel, addr, h);
    end
    if (e <= 1 + m) return pack(0, 1, 0, 0, sel, addr, e - 2);
    return pack(0, 0, 1, 1, sel, addr, m);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Called at a negedge; issues the request and follows it for n_edges edges.
  task automatic run_prog(input int sel, input int h, input int n_edges,
                          input int req_pulse_e, input int init_e);
    start_req = 1'b1;
    prog_sel  = sel[1:0];
    core_halt = 1'b0;
    for (int e = 1; e <= n_edges; e++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("a_sel%0d_h%0d_e%0d", sel, h, e), a_obs, expect_at(e, sel, h, MAX_A));
      check($sformatf("w_sel%0d_h%0d_e%0d", sel, h, e), w_obs, expect_at(e, sel, h, MAX_W));
      start_req = (e == req_pulse_e);
      core_halt = (e >= 2) && (e - 2 >= h);
      init      = (e == init_e);
    end
    start_req = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_a"}, a_obs, 32'd0);
    check({tag, "_w"}, w_obs, 32'd0);
  endtask

  initial begin
    int sel, h;
    init      = 1'b1;
    start_req = 1'b0;
    prog_sel  = 2'd0;
    core_halt = 1'b0;

    // reset held two cycles with a request pending; init must win
    start_req = 1'b1;
    check_idle("reset0");
    check_idle("reset1");
    start_req = 1'b0;
    init      = 1'b0;
    for (int i = 0; i < 5; i++) check_idle($sformatf("idle%0d", i));

    run_prog(1, 37, 42, 0, 0);   // normal run
    run_prog(0, 0, 5, 0, 0);     // immediate halt
    run_prog(2, 30, 35, 0, 0);   // short watchdog expires, long one completes
    run_prog(1, 9, 14, 0, 0);    // halt exactly at the watchdog boundary
    run_prog(3, 0, 4, 0, 0);     // invalid index
    run_prog(2, 12, 17, 0, 0);   // re-launch after fault

    // ignored request in RUN, then reset at count 5
    run_prog(0, 20, 7, 4, 7);
    check_idle("midrun_reset");
    init = 1'b0;
    check_idle("post_reset");

    for (int r = 0; r < 10; r++) begin
      sel = int'($urandom_range(0, 3));
      h   = int'($urandom_range(0, 40));
      run_prog(sel, h, h + 5, 0, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
